// File: rtl/alu_share_arbiter_if.sv
// Handshake bundle for the two-port ALU front end: two request channels,
// one response channel and the architectural carry/overflow flags.
interface alu_share_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [3:0]  req0_aluc;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [3:0]  req1_aluc;

    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [31:0] resp_result;
    logic        resp_zero;
    logic        resp_negative;
    logic        resp_carry;
    logic        resp_overflow;

    logic        flag_c;
    logic        flag_v;

    modport master (
        output req0_valid, req0_a, req0_b, req0_aluc,
        output req1_valid, req1_a, req1_b, req1_aluc,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_result,
        input  resp_zero, resp_negative, resp_carry, resp_overflow,
        input  flag_c, flag_v
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_aluc,
        input  req1_valid, req1_a, req1_b, req1_aluc,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_result,
        output resp_zero, resp_negative, resp_carry, resp_overflow,
        output flag_c, flag_v
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin front end sharing one 32-bit ALU between the EX stage (port 0)
// and the branch/compare unit (port 1), with a single registered response slot.
module alu_share_arbiter (
    input logic               clk,
    input logic               rst_n,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slotState_e;

    slotState_e  state_q;
    logic        last_q;
    logic        respId_q;
    logic [31:0] respResult_q;
    logic        respZero_q;
    logic        respNegative_q;
    logic        respCarry_q;
    logic        respOverflow_q;
    logic        flagC_q;
    logic        flagC_d;
    logic        flagV_q;
    logic        flagV_d;

    logic        slotFree;
    logic        grant;
    logic        accept;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [3:0]  opAluc;
    logic [31:0] aluResult;
    logic        aluCarry;
    logic        aluOverflow;
    logic [32:0] sum;
    logic [32:0] diff;
    logic [4:0]  shamt;

    // Idle grant defaults to port 0; on contention the port not served last wins.
    assign slotFree       = (state_q == EMPTY) || bus.resp_ready;
    assign grant          = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
    assign bus.req0_ready = slotFree && !grant;
    assign bus.req1_ready = slotFree && grant;
    assign accept         = (bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready);

    assign opA    = grant ? bus.req1_a    : bus.req0_a;
    assign opB    = grant ? bus.req1_b    : bus.req0_b;
    assign opAluc = grant ? bus.req1_aluc : bus.req0_aluc;

    // Shared ALU; shifts move opB by opA[4:0] and report the last bit shifted out as carry.
    always_comb begin
        sum         = {1'b0, opA} + {1'b0, opB};
        diff        = {1'b0, opA} - {1'b0, opB};
        shamt       = opA[4:0];
        aluResult   = '0;
        aluCarry    = 1'b0;
        aluOverflow = 1'b0;
        casez (opAluc)
            4'b00?0: begin
                aluResult   = sum[31:0];
                aluCarry    = sum[32];
                aluOverflow = opAluc[1] && (opA[31] == opB[31]) && (sum[31] != opA[31]);
            end
            4'b00?1: begin
                aluResult   = diff[31:0];
                aluCarry    = diff[32];
                aluOverflow = opAluc[1] && (opA[31] != opB[31]) && (diff[31] != opA[31]);
            end
            4'b0100: aluResult = opA & opB;
            4'b0101: aluResult = opA | opB;
            4'b0110: aluResult = opA ^ opB;
            4'b0111: aluResult = ~(opA | opB);
            4'b100?: aluResult = {opB[15:0], 16'h0000};
            4'b1010: begin
                aluResult = {31'b0, diff[32]};
                aluCarry  = diff[32];
            end
            4'b1011: aluResult = {31'b0, ($signed(opA) < $signed(opB))};
            4'b1100: begin
                aluResult = $signed(opB) >>> shamt;
                aluCarry  = (shamt != 5'd0) && opB[shamt - 5'd1];
            end
            4'b1101: begin
                aluResult = opB >> shamt;
                aluCarry  = (shamt != 5'd0) && opB[shamt - 5'd1];
            end
            default: begin
                aluResult = opB << shamt;
                aluCarry  = (shamt != 5'd0) && opB[5'd0 - shamt];
            end
        endcase
    end

    // Sticky flags only sample ALU values from ops that actually define them.
    always_comb begin
        flagC_d = flagC_q;
        flagV_d = flagV_q;
        if (accept) begin
            if (opAluc[3:1] == 3'b000 || opAluc == 4'b1010 || opAluc[3:2] == 2'b11) begin
                flagC_d = aluCarry;
            end
            if (opAluc[3:1] == 3'b001) begin
                flagV_d = aluOverflow;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= EMPTY;
            last_q         <= 1'b1;
            respId_q       <= 1'b0;
            respResult_q   <= '0;
            respZero_q     <= 1'b0;
            respNegative_q <= 1'b0;
            respCarry_q    <= 1'b0;
            respOverflow_q <= 1'b0;
            flagC_q        <= 1'b0;
            flagV_q        <= 1'b0;
        end else begin
            flagC_q <= flagC_d;
            flagV_q <= flagV_d;
            case (state_q)
                EMPTY:   if (accept) state_q <= FULL;
                FULL:    if (!accept && bus.resp_ready) state_q <= EMPTY;
                default: state_q <= EMPTY;
            endcase
            if (accept) begin
                last_q         <= grant;
                respId_q       <= grant;
                respResult_q   <= aluResult;
                respZero_q     <= (aluResult == 32'h0);
                respNegative_q <= aluResult[31];
                respCarry_q    <= aluCarry;
                respOverflow_q <= aluOverflow;
            end
        end
    end

    assign bus.resp_valid    = (state_q == FULL);
    assign bus.resp_id       = respId_q;
    assign bus.resp_result   = respResult_q;
    assign bus.resp_zero     = respZero_q;
    assign bus.resp_negative = respNegative_q;
    assign bus.resp_carry    = respCarry_q;
    assign bus.resp_overflow = respOverflow_q;
    assign bus.flag_c        = flagC_q;
    assign bus.flag_v        = flagV_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural model.
module tb_alu_share_arbiter;
    logic clk;
    logic rst_n;
    int   checkCount;
    int   errCount;
    bit   checkOn;

    alu_share_arbiter_if bus();

    alu_share_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic        mValid, mId, mZero, mNeg, mCarry, mOvf, mFlagC, mFlagV, mLast;
    logic [31:0] mResult;
    bit          acc0, acc1;
    int          take;
    logic [31:0] mA, mB, mR;
    logic [3:0]  mOp;
    logic        mC, mV;

    function automatic void aluRef(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic c, output logic v);
        logic [32:0] wide;
        logic [63:0] sh;
        int          s;
        s = int'(a[4:0]);
        r = 32'h0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'b0000, 4'b0010: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[31:0];
                c = wide[32];
                if (op == 4'b0010) v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'b0001, 4'b0011: begin
                r = a - b;
                c = (a < b);
                if (op == 4'b0011) v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'b0100: r = a & b;
            4'b0101: r = a | b;
            4'b0110: r = a ^ b;
            4'b0111: r = ~(a | b);
            4'b1000, 4'b1001: r = b << 16;
            4'b1010: begin
                r = (a < b) ? 32'd1 : 32'd0;
                c = (a < b);
            end
            4'b1011: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: begin
                sh = $signed({b, 32'h0}) >>> s;
                r = sh[63:32];
                c = sh[31];
            end
            4'b1101: begin
                sh = {b, 32'h0} >> s;
                r = sh[63:32];
                c = sh[31];
            end
            default: begin
                sh = {32'h0, b} << s;
                r = sh[31:0];
                c = sh[32];
            end
        endcase
    endfunction

    // Reference: pick a winner from the round-robin rule, compute the op, fill the slot.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mValid = 0; mId = 0; mResult = 0; mZero = 0; mNeg = 0; mCarry = 0; mOvf = 0;
            mFlagC = 0; mFlagV = 0; mLast = 1; acc0 = 0; acc1 = 0;
        end else begin
            take = -1;
            if (!mValid || bus.resp_ready) begin
                if (bus.req0_valid && bus.req1_valid) take = mLast ? 0 : 1;
                else if (bus.req0_valid) take = 0;
                else if (bus.req1_valid) take = 1;
            end
            acc0 = (take == 0);
            acc1 = (take == 1);
            if (take >= 0) begin
                mA  = (take == 1) ? bus.req1_a : bus.req0_a;
                mB  = (take == 1) ? bus.req1_b : bus.req0_b;
                mOp = (take == 1) ? bus.req1_aluc : bus.req0_aluc;
                aluRef(mOp, mA, mB, mR, mC, mV);
                mValid = 1; mId = (take == 1); mLast = (take == 1);
                mResult = mR; mZero = (mR == 0); mNeg = mR[31]; mCarry = mC; mOvf = mV;
                if (mOp inside {4'd0, 4'd1, 4'd10, 4'd12, 4'd13, 4'd14, 4'd15}) mFlagC = mC;
                if (mOp inside {4'd2, 4'd3}) mFlagV = mV;
            end else if (bus.resp_ready) begin
                mValid = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, {31'b0, actual}, {31'b0, expected});
    endtask

    always @(negedge clk) begin
        if (checkOn && rst_n) begin
            checkBit("resp_valid", bus.resp_valid, mValid);
            if (mValid) begin
                checkBit("resp_id", bus.resp_id, mId);
                checkOutput("resp_result", bus.resp_result, mResult);
                checkBit("resp_zero", bus.resp_zero, mZero);
                checkBit("resp_negative", bus.resp_negative, mNeg);
                checkBit("resp_carry", bus.resp_carry, mCarry);
                checkBit("resp_overflow", bus.resp_overflow, mOvf);
            end
            checkBit("flag_c", bus.flag_c, mFlagC);
            checkBit("flag_v", bus.flag_v, mFlagV);
            if (bus.req0_valid || bus.req1_valid) begin
                checkBit("req0_ready", bus.req0_ready,
                         (!mValid || bus.resp_ready) && (!bus.req1_valid || (bus.req0_valid && mLast)));
                checkBit("req1_ready", bus.req1_ready,
                         (!mValid || bus.resp_ready) && bus.req1_valid && (!bus.req0_valid || !mLast));
            end
        end
    end

    task automatic applyStimulus(input bit v0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] op0,
                                 input bit v1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] op1,
                                 input bit rr);
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_aluc = op0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_aluc = op1;
        bus.resp_ready = rr;
    endtask

    task automatic idle(input bit rr);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, rr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        checkCount = 0;
        errCount   = 0;
        checkOn    = 0;
        rst_n      = 1'b0;
        idle(1);
        #12;
        rst_n   = 1'b1;
        checkOn = 1;
        checkBit("reset resp_valid", bus.resp_valid, 1'b0);
        checkOutput("reset resp_result", bus.resp_result, 32'h0);
        checkBit("reset flag_c", bus.flag_c, 1'b0);
        checkBit("reset flag_v", bus.flag_v, 1'b0);

        // Signed add overflow from port 0.
        applyStimulus(1, 32'h7FFF_FFFF, 32'h1, 4'b0010, 0, 0, 0, 0, 1);
        tick();
        idle(1);
        checkOutput("add result", bus.resp_result, 32'h8000_0000);
        checkBit("add overflow", bus.resp_overflow, 1'b1);
        checkBit("add negative", bus.resp_negative, 1'b1);
        checkBit("add flag_v", bus.flag_v, 1'b1);
        checkBit("add id", bus.resp_id, 1'b0);

        // Continuous contention alternates starting with port 0.
        doReset();
        applyStimulus(1, 32'd1, 32'd1, 4'b0000, 1, 32'd2, 32'd3, 4'b0000, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkBit("rr id", bus.resp_id, 1'(i % 2));
            checkOutput("rr result", bus.resp_result, (i % 2 == 0) ? 32'd2 : 32'd5);
        end

        // subu borrow sets flag_c; a logical op leaves both sticky flags alone.
        applyStimulus(0, 0, 0, 0, 1, 32'd1, 32'd2, 4'b0001, 1);
        tick();
        checkOutput("subu result", bus.resp_result, 32'hFFFF_FFFF);
        checkBit("subu flag_c", bus.flag_c, 1'b1);
        applyStimulus(0, 0, 0, 0, 1, 32'h0000_F0F0, 32'h0000_0FF0, 4'b0100, 1);
        tick();
        checkOutput("and result", bus.resp_result, 32'h0000_00F0);
        checkBit("and flag_c", bus.flag_c, 1'b1);
        checkBit("and flag_v", bus.flag_v, 1'b0);

        // Stalled slot blocks both ports and freezes the response.
        applyStimulus(1, 32'h30, 32'h03, 4'b0101, 1, 32'd5, 32'd3, 4'b0110, 0);
        #1;
        checkBit("stall ready0", bus.req0_ready, 1'b0);
        checkBit("stall ready1", bus.req1_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkBit("stall valid", bus.resp_valid, 1'b1);
            checkOutput("stall result", bus.resp_result, 32'h0000_00F0);
            checkBit("stall id", bus.resp_id, 1'b1);
        end
        bus.resp_ready = 1'b1;
        #1;
        checkBit("release ready0", bus.req0_ready, 1'b1);
        checkBit("release ready1", bus.req1_ready, 1'b0);
        tick();
        idle(1);
        checkBit("release id", bus.resp_id, 1'b0);
        checkOutput("release result", bus.resp_result, 32'h0000_0033);

        // Signed vs unsigned compare of the same operands.
        applyStimulus(1, 32'hFFFF_FFFF, 32'h1, 4'b1011, 0, 0, 0, 0, 1);
        tick();
        checkOutput("slt result", bus.resp_result, 32'd1);
        checkBit("slt zero", bus.resp_zero, 1'b0);
        applyStimulus(1, 32'hFFFF_FFFF, 32'h1, 4'b1010, 0, 0, 0, 0, 1);
        tick();
        checkOutput("sltu result", bus.resp_result, 32'd0);
        checkBit("sltu zero", bus.resp_zero, 1'b1);
        checkBit("sltu flag_c", bus.flag_c, 1'b0);

        // Asynchronous reset with a full slot clears it without a clock edge.
        applyStimulus(1, 32'h7FFF_FFFF, 32'h1, 4'b0010, 0, 0, 0, 0, 1);
        tick();
        idle(0);
        checkBit("pre-reset valid", bus.resp_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkBit("async resp_valid", bus.resp_valid, 1'b0);
        checkOutput("async resp_result", bus.resp_result, 32'h0);
        checkBit("async flag_v", bus.flag_v, 1'b0);
        checkBit("async resp_overflow", bus.resp_overflow, 1'b0);
        checkBit("async resp_negative", bus.resp_negative, 1'b0);
        #3;
        rst_n = 1'b1;

        // Random traffic; a port that was not accepted holds its request.
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!(bus.req0_valid && !acc0)) begin
                bus.req0_valid = ($urandom_range(0, 9) < 7);
                bus.req0_a     = pickOperand();
                bus.req0_b     = pickOperand();
                bus.req0_aluc  = 4'($urandom_range(0, 15));
            end
            if (!(bus.req1_valid && !acc1)) begin
                bus.req1_valid = ($urandom_range(0, 9) < 7);
                bus.req1_a     = pickOperand();
                bus.req1_b     = pickOperand();
                bus.req1_aluc  = 4'($urandom_range(0, 15));
            end
            bus.resp_ready = (cyc < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) < 3);
            tick();
        end
        idle(1);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule
